// File: rtl/aes_bist_controller.sv
// AES BIST sequencer: LFSR stimulus, one-at-a-time core launch, one ORA enable per
// result, and a final signature compare against a golden value.
module aes_bist_controller #(
    parameter int unsigned  NUM_VECTORS = 62,
    parameter logic [127:0] SEED        = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
    parameter logic [31:0]  GOLDEN_SIG  = 32'h0000_0000,
    parameter int unsigned  TIMEOUT     = 255,
    parameter int unsigned  ORA_LAT     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bist_start,
    output logic [127:0] pattern,
    output logic         cut_start,
    input  logic         cut_done,
    output logic         ora_clear,
    output logic         ora_enable,
    input  logic [31:0]  ora_sig,
    output logic         bist_busy,
    output logic         bist_done,
    output logic         bist_pass,
    output logic         bist_timeout,
    output logic [7:0]   vec_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_LAUNCH, S_WAIT, S_COMPACT,
        S_NEXT, S_SETTLE, S_COMPARE, S_DONE
    } state_t;

    localparam logic [7:0] NUM_V    = 8'(NUM_VECTORS);
    localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);
    localparam logic [9:0] ORA_LAST = 10'(ORA_LAT - 1);

    state_t       state_q, state_d;
    logic [127:0] pattern_q, pattern_d;
    logic [7:0]   vec_count_q, vec_count_d;
    logic [9:0]   cnt_q, cnt_d;
    logic         pass_q, pass_d;
    logic         timeout_q, timeout_d;
    logic         cut_start_q, cut_start_d;
    logic         ora_clear_q, ora_clear_d;
    logic         ora_enable_q, ora_enable_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    function automatic logic [127:0] lfsr_next(input logic [127:0] p);
        return {p[126:0], p[127] ^ p[125] ^ p[100] ^ p[98]};
    endfunction

    // Data updates happen on entry to a state so every output is a flop that
    // already reflects the state it belongs to.
    always_comb begin
        state_d     = state_q;
        pattern_d   = pattern_q;
        vec_count_d = vec_count_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bist_start) begin
                    state_d     = S_CLEAR;
                    pattern_d   = SEED;
                    vec_count_d = 8'd0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = S_LAUNCH;
                cnt_d   = 10'd0;
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = 10'd0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 10'd1;
                if (cut_done) begin
                    state_d = S_COMPACT;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            S_COMPACT: begin
                state_d     = S_NEXT;
                pattern_d   = lfsr_next(pattern_q);
                vec_count_d = (vec_count_q == NUM_V) ? vec_count_q : vec_count_q + 8'd1;
            end
            S_NEXT: begin
                if (vec_count_q == NUM_V) begin
                    state_d = S_SETTLE;
                    cnt_d   = 10'd0;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q == ORA_LAST) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                state_d = S_DONE;
                pass_d  = (ora_sig == GOLDEN_SIG);
            end
            default: state_d = S_IDLE;
        endcase

        cut_start_d  = (state_d == S_LAUNCH);
        ora_clear_d  = (state_d == S_CLEAR);
        ora_enable_d = (state_d == S_COMPACT);
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pattern_q    <= SEED;
            vec_count_q  <= 8'd0;
            cnt_q        <= 10'd0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cut_start_q  <= 1'b0;
            ora_clear_q  <= 1'b0;
            ora_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pattern_q    <= pattern_d;
            vec_count_q  <= vec_count_d;
            cnt_q        <= cnt_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            cut_start_q  <= cut_start_d;
            ora_clear_q  <= ora_clear_d;
            ora_enable_q <= ora_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign pattern      = pattern_q;
    assign vec_count    = vec_count_q;
    assign cut_start    = cut_start_q;
    assign ora_clear    = ora_clear_q;
    assign ora_enable   = ora_enable_q;
    assign bist_busy    = busy_q;
    assign bist_done    = done_q;
    assign bist_pass    = pass_q;
    assign bist_timeout = timeout_q;

endmodule
